dds_sweep_master: RTL and testbench
===================================

Name: dds_sweep_master

Overview:
- ICB master that sits directly upstream of the DDS register slave and drives its command port.
- Steps the DDS frequency word (register 0x04) from a start value to a stop value in fixed increments.
- Holds each frequency for a programmable dwell time.
- Supports single-shot or continuous sweeps, so a frequency sweep runs without CPU involvement.

Parameters:
- DDS_BASE, 32'h0000_0000, base address of the DDS register block; frequency register at DDS_BASE+32'h04.
- DWELL_W, 24, width of the dwell counter.
- WRAP_W, 16, width of the continuous-mode wrap counter.

Ports:
- sys_clk  in  1  single clock; all logic on its rising edge.
- sys_rst_n  in  1  reset; synchronous, active-low.
- start  in  1  single-cycle request; latches the configuration and begins a sweep.
- stop  in  1  single-cycle request to abort the sweep.
- continuous  in  1  1 = wrap back to f_start at the end; 0 = single sweep. Latched on start.
- f_start  in  32  first frequency word. Latched on start.
- f_stop  in  32  last allowed frequency word, inclusive. Latched on start.
- f_step  in  32  increment per step. Latched on start.
- dwell  in  DWELL_W  extra hold cycles per point. Latched on start.
- dds_icb_cmd_valid  out  1  command valid.
- dds_icb_cmd_ready  in  1  command ready from the slave.
- dds_icb_cmd_addr  out  32  command address.
- dds_icb_cmd_read  out  1  read enable; always 0.
- dds_icb_cmd_wdata  out  32  write data.
- dds_icb_cmd_wmask  out  4  write mask; always 4'hF.
- dds_icb_rsp_valid  in  1  response valid.
- dds_icb_rsp_ready  out  1  response ready; always 1.
- dds_icb_rsp_err  in  1  response error.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when a single sweep completes naturally.
- cur_freq  out  32  frequency word currently issued or held.
- wrap_cnt  out  WRAP_W  number of wraps in continuous mode.
- err_flag  out  1  sticky; set on dds_icb_rsp_valid & dds_icb_rsp_err.

Behaviour:
- Reset (sys_rst_n=0 at a sys_clk edge):
  - state=IDLE.
  - cmd_valid=0, cmd_addr=0, cmd_wdata=0.
  - busy=0, done=0, cur_freq=0, wrap_cnt=0, err_flag=0.
  - Reset mid-handshake drops cmd_valid on that edge; no further write is issued.
- Write completion is the cmd handshake (valid & ready at a clock edge). The slave issues no response for writes; incoming responses are consumed only to update err_flag.
- States: IDLE, WRITE, DWELL.
- IDLE:
  - start=1 → latch config, cur_freq<=f_start, wrap_cnt<=0, err_flag<=0, go WRITE.
  - cmd_valid rises the cycle after start.
- WRITE:
  - cmd_valid=1, cmd_addr=DDS_BASE+4, cmd_wdata=cur_freq.
  - addr and wdata stay stable until the handshake.
  - On handshake: cnt<=dwell, go DWELL.
  - cmd_valid is never withdrawn before the handshake, even if stop is seen.
- DWELL:
  - cnt!=0 → cnt decrements.
  - cnt==0 → step decision, so DWELL lasts dwell+1 cycles.
  - With ready tied high, write period = dwell+2 cycles.
- Step decision, computed in 33 bits: nxt = cur_freq + f_step. End is reached if f_step==0, or nxt > f_stop, or cur_freq >= f_stop.
  - Not end → cur_freq<=nxt[31:0], go WRITE.
  - End, continuous=1 → cur_freq<=f_start_lat, wrap_cnt++ (wraps modulo 2^WRAP_W), go WRITE.
  - End, continuous=0 → done=1 for one cycle, go IDLE; cur_freq holds its last value.
- f_start > f_stop: exactly one write of f_start, then end handling applies.
- stop:
  - In DWELL → IDLE next edge, no done.
  - In WRITE → set stop_pending; after the handshake go IDLE instead of DWELL.
  - In IDLE → ignored.
  - stop and start in the same cycle in IDLE → start wins.
- start while busy: ignored; the latched config is unchanged.
- Input config changes after start have no effect until the next start.
- busy = (state != IDLE).

Test Plan:
- Single sweep: f_start=100, f_step=50, f_stop=250, dwell=3, ready=1 → wdata 100, 150, 200, 250 at addr 0x04, handshakes 5 cycles apart; done pulses 5 cycles after the last handshake; busy then 0.
- Overshoot: f_start=100, f_step=60, f_stop=250 → writes 100, 160, 220 only; done asserted; cur_freq=220.
- Continuous: f_start=10, f_step=10, f_stop=30, dwell=0 → sequence 10, 20, 30, 10, 20, …; wrap_cnt=1 after the 4th write; no done.
- Backpressure plus stop: ready held low 7 cycles with stop pulsed in WRITE → cmd_valid, addr and wdata stable throughout; one handshake when ready rises; IDLE on the next edge; no done.
- Edge cases: f_step=0 gives one write then done; f_start=300 > f_stop=200 gives one write of 300 then done; dwell=0 gives a 2-cycle write period.
- Reset and error: sys_rst_n low during DWELL → all outputs at reset values next edge. rsp_valid=1 with rsp_err=1 → err_flag=1 and held until the next start.

Source files
------------

// File: rtl/dds_sweep_master.sv
// DDS frequency sweep master.
// Drives the DDS register slave's ICB command port. It steps the frequency
// word from f_start towards f_stop in f_step increments and holds each point
// for a programmable dwell time. A sweep either runs once or wraps around.
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no sweep running; a start pulse latches the configuration
// WRITE | cmd_valid held high with the current frequency until the handshake
// DWELL | dwell down-counter running; at terminal count decide the next point

module dds_sweep_master #(
    parameter logic [31:0] DDS_BASE = 32'h0000_0000,
    parameter int          DWELL_W  = 24,
    parameter int          WRAP_W   = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [31:0]        f_start,
    input  logic [31:0]        f_stop,
    input  logic [31:0]        f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic               dds_icb_cmd_valid,
    input  logic               dds_icb_cmd_ready,
    output logic [31:0]        dds_icb_cmd_addr,
    output logic               dds_icb_cmd_read,
    output logic [31:0]        dds_icb_cmd_wdata,
    output logic [3:0]         dds_icb_cmd_wmask,
    input  logic               dds_icb_rsp_valid,
    output logic               dds_icb_rsp_ready,
    input  logic               dds_icb_rsp_err,
    output logic               busy,
    output logic               done,
    output logic [31:0]        cur_freq,
    output logic [WRAP_W-1:0]  wrap_cnt,
    output logic               err_flag
);

    localparam logic [31:0] FREQ_ADDR = DDS_BASE + 32'h0000_0004;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DWELL = 2'd2
    } state_t;

    state_t             state;
    logic               cont_lat;
    logic [31:0]        f_start_lat;
    logic [31:0]        f_stop_lat;
    logic [31:0]        f_step_lat;
    logic [DWELL_W-1:0] dwell_lat;
    logic [DWELL_W-1:0] cnt;
    logic               stop_pending;
    logic [32:0]        nxt;
    logic               at_end;

    // Next point is computed one bit wider so a step past 2^32-1 counts as
    // overshooting f_stop instead of wrapping to a small value.
    assign nxt    = {1'b0, cur_freq} + {1'b0, f_step_lat};
    assign at_end = (f_step_lat == 32'd0) || (nxt > {1'b0, f_stop_lat}) ||
                    (cur_freq >= f_stop_lat);

    assign busy              = (state != IDLE);
    assign dds_icb_cmd_wdata = cur_freq;
    assign dds_icb_cmd_read  = 1'b0;
    assign dds_icb_cmd_wmask = 4'hF;
    assign dds_icb_rsp_ready = 1'b1;

    // Sweep sequencer: config latch, command issue, dwell timer and step decision.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state             <= IDLE;
            cont_lat          <= 1'b0;
            f_start_lat       <= 32'd0;
            f_stop_lat        <= 32'd0;
            f_step_lat        <= 32'd0;
            dwell_lat         <= '0;
            cnt               <= '0;
            stop_pending      <= 1'b0;
            dds_icb_cmd_valid <= 1'b0;
            dds_icb_cmd_addr  <= 32'd0;
            done              <= 1'b0;
            cur_freq          <= 32'd0;
            wrap_cnt          <= '0;
            err_flag          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cont_lat          <= continuous;
                        f_start_lat       <= f_start;
                        f_stop_lat        <= f_stop;
                        f_step_lat        <= f_step;
                        dwell_lat         <= dwell;
                        cur_freq          <= f_start;
                        wrap_cnt          <= '0;
                        err_flag          <= 1'b0;
                        stop_pending      <= 1'b0;
                        dds_icb_cmd_valid <= 1'b1;
                        dds_icb_cmd_addr  <= FREQ_ADDR;
                        state             <= WRITE;
                    end
                end
                WRITE: begin
                    // The command is never withdrawn; a stop only redirects
                    // where we go once the slave has taken it.
                    if (stop) begin
                        stop_pending <= 1'b1;
                    end
                    if (dds_icb_cmd_ready) begin
                        dds_icb_cmd_valid <= 1'b0;
                        stop_pending      <= 1'b0;
                        if (stop_pending || stop) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= dwell_lat;
                            state <= DWELL;
                        end
                    end
                end
                DWELL: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!at_end) begin
                        cur_freq          <= nxt[31:0];
                        dds_icb_cmd_valid <= 1'b1;
                        state             <= WRITE;
                    end else if (cont_lat) begin
                        cur_freq          <= f_start_lat;
                        wrap_cnt          <= wrap_cnt + 1'b1;
                        dds_icb_cmd_valid <= 1'b1;
                        state             <= WRITE;
                    end else begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    dds_icb_cmd_valid <= 1'b0;
                    state             <= IDLE;
                end
            endcase
            // Write responses are not expected; any error response is remembered.
            if (dds_icb_rsp_valid && dds_icb_rsp_err) begin
                err_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_master.sv
// Self-checking bench for dds_sweep_master: vector table, hand-written
// corner sequences and randomized sweeps against a list-based sweep model.

module tb_dds_sweep_master;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start, stop, continuous;
    logic [31:0] f_start, f_stop, f_step;
    logic [23:0] dwell;
    logic        dds_icb_cmd_valid, dds_icb_cmd_ready;
    logic [31:0] dds_icb_cmd_addr, dds_icb_cmd_wdata;
    logic        dds_icb_cmd_read;
    logic [3:0]  dds_icb_cmd_wmask;
    logic        dds_icb_rsp_valid, dds_icb_rsp_ready, dds_icb_rsp_err;
    logic        busy, done, err_flag;
    logic [31:0] cur_freq;
    logic [15:0] wrap_cnt;

    dds_sweep_master dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
        .continuous(continuous), .f_start(f_start), .f_stop(f_stop),
        .f_step(f_step), .dwell(dwell),
        .dds_icb_cmd_valid(dds_icb_cmd_valid), .dds_icb_cmd_ready(dds_icb_cmd_ready),
        .dds_icb_cmd_addr(dds_icb_cmd_addr), .dds_icb_cmd_read(dds_icb_cmd_read),
        .dds_icb_cmd_wdata(dds_icb_cmd_wdata), .dds_icb_cmd_wmask(dds_icb_cmd_wmask),
        .dds_icb_rsp_valid(dds_icb_rsp_valid), .dds_icb_rsp_ready(dds_icb_rsp_ready),
        .dds_icb_rsp_err(dds_icb_rsp_err), .busy(busy), .done(done),
        .cur_freq(cur_freq), .wrap_cnt(wrap_cnt), .err_flag(err_flag)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [31:0] fs;
        logic [31:0] fe;
        logic [31:0] st;
        logic [23:0] dw;
        logic        cont;
    } cfg_t;

    typedef struct packed {
        cfg_t        c;
        int          n_writes;
        logic [31:0] last;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    bit          rr = 1'b0;
    logic [31:0] hs_data[$];
    logic [31:0] hs_addr[$];
    int          hs_cyc[$];
    int          hs_wrap[$];
    logic [31:0] exp_q[$];
    vec_t        vecs[7];

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Handshake and done logger, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (dds_icb_cmd_valid === 1'b1 && dds_icb_cmd_ready === 1'b1) begin
            hs_data.push_back(dds_icb_cmd_wdata);
            hs_addr.push_back(dds_icb_cmd_addr);
            hs_cyc.push_back(cyc);
            hs_wrap.push_back(int'(wrap_cnt));
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Expected frequency list: start, then keep adding the step while the
    // result stays at or below f_stop.
    function automatic void build_expected(cfg_t c);
        longint unsigned f;
        exp_q.delete();
        f = longint'(c.fs);
        exp_q.push_back(c.fs);
        while (c.st != 0 && f < longint'(c.fe) && f + longint'(c.st) <= longint'(c.fe)) begin
            f = f + longint'(c.st);
            exp_q.push_back(f[31:0]);
        end
    endfunction

    function automatic vec_t mk(logic [31:0] fs, logic [31:0] fe, logic [31:0] st,
                                logic [23:0] dw, int n, logic [31:0] last);
        vec_t v;
        v.c.fs = fs; v.c.fe = fe; v.c.st = st; v.c.dw = dw; v.c.cont = 1'b0;
        v.n_writes = n; v.last = last;
        return v;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (rr) dds_icb_cmd_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic launch(cfg_t c);
        continuous = c.cont; f_start = c.fs; f_stop = c.fe; f_step = c.st; dwell = c.dw;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("valid_after_start", dds_icb_cmd_valid, 1'b1);
        // Changing the inputs after the start pulse must not affect the sweep.
        continuous = $urandom_range(0, 1); f_start = $urandom; f_stop = $urandom;
        f_step = $urandom; dwell = 24'($urandom_range(0, 3));
    endtask

    task automatic run_sweep(cfg_t c, output int base, output int dbase);
        base  = hs_data.size();
        dbase = done_cnt;
        launch(c);
        for (int i = 0; i < 20000 && busy; i++) tick();
        check("sweep_ends", busy, 1'b0);
        tick();
    endtask

    task automatic check_against_model(cfg_t c, int base, int dbase, string tag);
        int n;
        build_expected(c);
        n = hs_data.size() - base;
        check({tag, "_n_writes"}, n, exp_q.size());
        for (int k = 0; k < n && k < exp_q.size(); k++) begin
            check({tag, "_wdata"}, hs_data[base+k], exp_q[k]);
            check({tag, "_addr"}, hs_addr[base+k], 32'h4);
        end
        check({tag, "_done_count"}, done_cnt - dbase, 1);
        check({tag, "_cur_freq"}, cur_freq, exp_q[exp_q.size()-1]);
    endtask

    initial begin
        int   base, dbase, n;
        cfg_t c;

        vecs[0] = mk(32'd100, 32'd250, 32'd50, 24'd3, 4, 32'd250);
        vecs[1] = mk(32'd100, 32'd250, 32'd60, 24'd3, 3, 32'd220);
        vecs[2] = mk(32'd100, 32'd500, 32'd0,  24'd2, 1, 32'd100);
        vecs[3] = mk(32'd300, 32'd200, 32'd10, 24'd1, 1, 32'd300);
        vecs[4] = mk(32'd5,   32'd20,  32'd5,  24'd0, 4, 32'd20);
        vecs[5] = mk(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd8, 24'd1, 2, 32'hFFFF_FFF8);
        vecs[6] = mk(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 24'd0, 2, 32'hFFFF_FFFF);

        sys_rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        f_start = 32'd0; f_stop = 32'd0; f_step = 32'd0; dwell = 24'd0;
        dds_icb_cmd_ready = 1'b1; dds_icb_rsp_valid = 1'b0; dds_icb_rsp_err = 1'b0;
        tick(); tick(); tick();

        check("rst_valid", dds_icb_cmd_valid, 1'b0);
        check("rst_addr", dds_icb_cmd_addr, 32'h0);
        check("rst_wdata", dds_icb_cmd_wdata, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cur_freq", cur_freq, 32'h0);
        check("rst_wrap_cnt", wrap_cnt, 16'h0);
        check("rst_err_flag", err_flag, 1'b0);
        check("cmd_read", dds_icb_cmd_read, 1'b0);
        check("cmd_wmask", dds_icb_cmd_wmask, 4'hF);
        check("rsp_ready", dds_icb_rsp_ready, 1'b1);
        sys_rst_n = 1'b1;
        tick();

        // Stop alone in IDLE does nothing.
        stop = 1'b1; tick(); stop = 1'b0; tick();
        check("stop_in_idle_busy", busy, 1'b0);
        check("stop_in_idle_valid", dds_icb_cmd_valid, 1'b0);

        // Table-driven single sweeps with ready tied high.
        for (int v = 0; v < 7; v++) begin
            run_sweep(vecs[v].c, base, dbase);
            n = hs_data.size() - base;
            check("vec_n_writes", n, vecs[v].n_writes);
            if (n > 0) check("vec_last_wdata", hs_data[base+n-1], vecs[v].last);
            check("vec_cur_freq", cur_freq, vecs[v].last);
            check_against_model(vecs[v].c, base, dbase, "vec");
            for (int k = 1; k < n; k++)
                check("vec_period", hs_cyc[base+k] - hs_cyc[base+k-1], vecs[v].c.dw + 2);
            if (n > 0) check("vec_done_delay", done_cyc - hs_cyc[base+n-1], vecs[v].c.dw + 2);
        end

        // Continuous sweep with a start attempt while busy, then stop.
        c = '{fs: 32'd10, fe: 32'd30, st: 32'd10, dw: 24'd0, cont: 1'b1};
        base = hs_data.size(); dbase = done_cnt;
        launch(c);
        tick(); tick();
        f_start = 32'd999; f_stop = 32'd5000; f_step = 32'd1; continuous = 1'b0; dwell = 24'd7;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 500 && (hs_data.size() - base) < 7; i++) tick();
        check("cont_writes_seen", (hs_data.size() - base) >= 7, 1'b1);
        build_expected(c);
        for (int k = 0; k < 7 && base + k < hs_data.size(); k++) begin
            check("cont_wdata", hs_data[base+k], exp_q[k % exp_q.size()]);
            check("cont_wrap_cnt", hs_wrap[base+k], k / exp_q.size());
            if (k > 0) check("cont_period", hs_cyc[base+k] - hs_cyc[base+k-1], 2);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        for (int i = 0; i < 10 && busy; i++) tick();
        tick();
        check("cont_stop_busy", busy, 1'b0);
        check("cont_no_done", done_cnt - dbase, 0);

        // Backpressure with a stop seen during WRITE.
        dds_icb_cmd_ready = 1'b0;
        c = '{fs: 32'd1000, fe: 32'd2000, st: 32'd100, dw: 24'd1, cont: 1'b0};
        base = hs_data.size(); dbase = done_cnt;
        launch(c);
        check("bp_addr", dds_icb_cmd_addr, 32'h4);
        check("bp_wdata", dds_icb_cmd_wdata, 32'd1000);
        stop = 1'b1; tick(); stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("bp_valid_held", dds_icb_cmd_valid, 1'b1);
            check("bp_addr_held", dds_icb_cmd_addr, 32'h4);
            check("bp_wdata_held", dds_icb_cmd_wdata, 32'd1000);
            tick();
        end
        dds_icb_cmd_ready = 1'b1;
        tick();
        check("bp_idle_after_hs", busy, 1'b0);
        check("bp_valid_dropped", dds_icb_cmd_valid, 1'b0);
        tick(); tick(); tick();
        check("bp_one_handshake", hs_data.size() - base, 1);
        if (hs_data.size() > base) check("bp_hs_wdata", hs_data[base], 32'd1000);
        check("bp_no_done", done_cnt - dbase, 0);

        // Error flag: sticky, cleared only by the next start.
        dds_icb_rsp_valid = 1'b1; dds_icb_rsp_err = 1'b1; tick();
        dds_icb_rsp_valid = 1'b0; dds_icb_rsp_err = 1'b0;
        check("err_set", err_flag, 1'b1);
        dds_icb_rsp_valid = 1'b1; tick(); dds_icb_rsp_valid = 1'b0; tick(); tick();
        check("err_held", err_flag, 1'b1);

        // Reset during DWELL.
        c = '{fs: 32'd500, fe: 32'd900, st: 32'd100, dw: 24'd10, cont: 1'b0};
        base = hs_data.size();
        launch(c);
        check("err_cleared_by_start", err_flag, 1'b0);
        for (int i = 0; i < 50 && hs_data.size() == base; i++) tick();
        tick(); tick(); tick();
        dds_icb_rsp_valid = 1'b1; dds_icb_rsp_err = 1'b1; tick();
        dds_icb_rsp_valid = 1'b0; dds_icb_rsp_err = 1'b0;
        check("rst_pre_busy", busy, 1'b1);
        sys_rst_n = 1'b0; tick();
        check("rst2_valid", dds_icb_cmd_valid, 1'b0);
        check("rst2_addr", dds_icb_cmd_addr, 32'h0);
        check("rst2_wdata", dds_icb_cmd_wdata, 32'h0);
        check("rst2_busy", busy, 1'b0);
        check("rst2_done", done, 1'b0);
        check("rst2_cur_freq", cur_freq, 32'h0);
        check("rst2_wrap_cnt", wrap_cnt, 16'h0);
        check("rst2_err_flag", err_flag, 1'b0);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("rst2_no_more_writes", hs_data.size() - base, 1);
        check("rst2_stays_idle", busy, 1'b0);

        // Randomized single sweeps with random backpressure.
        rr = 1'b1;
        for (int it = 0; it < 24; it++) begin
            if (it % 6 == 5) begin
                c.fs = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
                c.fe = 32'hFFFF_FF80 + 32'($urandom_range(0, 127));
                c.st = 32'($urandom_range(16, 100));
            end else begin
                c.fs = 32'($urandom_range(0, 200));
                c.fe = 32'($urandom_range(0, 300));
                c.st = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(3, 40));
            end
            c.dw   = 24'($urandom_range(0, 4));
            c.cont = 1'b0;
            run_sweep(c, base, dbase);
            check_against_model(c, base, dbase, "rand");
        end
        rr = 1'b0;
        dds_icb_cmd_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
